// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD countdown timer: prescaled 1 s tick, start/pause/clear FSM,
// terminal-count detection and a registered two-slot display multiplexer.
module bcd_timer_ctrl #(
  parameter int CLK_DIV  = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       done,
  output logic       digit_sel,
  output logic [3:0] digit_bcd
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q;
  logic [3:0]    tens_d, ones_d;
  logic [3:0]    ld_tens, ld_ones;
  logic [3:0]    dec_tens, dec_ones;
  logic          ld_zero, tick;

  function automatic logic [3:0] sat_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Borrow from tens when ones is already zero.
  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd0) return {t, o - 4'd1};
    else           return {t - 4'd1, 4'd9};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      bcd_tens <= tens_d;
      bcd_ones <= ones_d;
      running  <= (state_q == S_RUN);
      done     <= (state_q == S_DONE);
    end
  end

  always_comb begin
    ld_tens  = sat_bcd(preset_tens);
    ld_ones  = sat_bcd(preset_ones);
    ld_zero  = (ld_tens == 4'd0) && (ld_ones == 4'd0);
    tick     = (state_q == S_RUN) && (pre_q == PRE_LAST);
    {dec_tens, dec_ones} = bcd_dec(bcd_tens, bcd_ones);
    state_d  = state_q;
    pre_d    = pre_q;
    tens_d   = bcd_tens;
    ones_d   = bcd_ones;
    if (clear) begin
      state_d = S_IDLE;
      pre_d   = '0;
      tens_d  = ld_tens;
      ones_d  = ld_ones;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_IDLE || start) begin
            tens_d = ld_tens;
            ones_d = ld_ones;
          end
          if (start) begin
            pre_d   = '0;
            state_d = ld_zero ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          // A pause on the tick edge still takes the decrement; otherwise the
          // prescaler is held where it stands.
          if (tick) begin
            pre_d  = '0;
            tens_d = dec_tens;
            ones_d = dec_ones;
            if (dec_tens == 4'd0 && dec_ones == 4'd0) state_d = S_DONE;
            else if (pause)                            state_d = S_PAUSE;
          end else if (pause) begin
            state_d = S_PAUSE;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Display scan runs freely, independent of the timer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_q    <= '0;
      digit_sel <= 1'b0;
      digit_bcd <= 4'd0;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q    <= '0;
        digit_sel <= ~digit_sel;
      end else begin
        scan_q <= scan_q + SW'(1);
      end
      digit_bcd <= digit_sel ? bcd_tens : bcd_ones;
    end
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl (CLK_DIV=4, SCAN_DIV=3): vector table
// plus hand sequences for pause/resume, terminal hold, async reset and scan.
module tb_bcd_timer_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [3:0] preset_tens = 4'd0, preset_ones = 4'd0;
  logic [3:0] bcd_tens, bcd_ones, digit_bcd;
  logic       running, done, digit_sel;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_timer_ctrl #(.CLK_DIV(4), .SCAN_DIV(3)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause),
    .clear(clear), .preset_tens(preset_tens), .preset_ones(preset_ones),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .running(running),
    .done(done), .digit_sel(digit_sel), .digit_bcd(digit_bcd)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st, pa, cl;
    logic [3:0] pt, po;
    logic [3:0] et, eo;
    logic       er, ed;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic st, input logic pa, input logic cl,
                     input logic [3:0] pt, input logic [3:0] po,
                     input logic [3:0] et, input logic [3:0] eo,
                     input logic er, input logic ed);
    vec_t v;
    v.st = st; v.pa = pa; v.cl = cl; v.pt = pt; v.po = po;
    v.et = et; v.eo = eo; v.er = er; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_digits(input string name, input logic [3:0] t, input logic [3:0] o);
    chk(name, {bcd_tens, bcd_ones}, {t, o});
  endtask

  task automatic pulse(input int which);
    if (which == 0) start = 1'b1;
    if (which == 1) pause = 1'b1;
    if (which == 2) clear = 1'b1;
    step(1);
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  logic exp_sel, prev_sel;
  logic [3:0] exp_dbcd;

  initial begin
    // Vector table: inputs sampled on an edge, outputs checked just after it.
    // A: preset 12 countdown, then clear+start together in RUN.
    add(1,0,0, 1,2, 1,2, 0,0);
    add(0,0,0, 1,2, 1,2, 1,0);
    add(0,0,0, 1,2, 1,2, 1,0);
    add(0,0,0, 1,2, 1,2, 1,0);
    add(0,0,0, 1,2, 1,1, 1,0);
    add(0,0,0, 1,2, 1,1, 1,0);
    add(0,0,0, 1,2, 1,1, 1,0);
    add(0,0,0, 1,2, 1,1, 1,0);
    add(0,0,0, 1,2, 1,0, 1,0);
    add(0,0,0, 1,2, 1,0, 1,0);
    add(0,0,0, 1,2, 1,0, 1,0);
    add(0,0,0, 1,2, 1,0, 1,0);
    add(0,0,0, 1,2, 0,9, 1,0);
    add(0,0,0, 1,2, 0,9, 1,0);
    add(0,0,0, 1,2, 0,9, 1,0);
    add(0,0,0, 1,2, 0,9, 1,0);
    add(0,0,0, 1,2, 0,8, 1,0);
    add(1,0,1, 1,2, 1,2, 1,0);
    add(0,0,0, 1,2, 1,2, 0,0);
    add(0,1,0, 1,2, 1,2, 0,0);
    // B: preset 01 reaches terminal count on the first tick.
    add(0,0,0, 0,1, 0,1, 0,0);
    add(1,0,0, 0,1, 0,1, 0,0);
    add(0,0,0, 0,1, 0,1, 1,0);
    add(0,0,0, 0,1, 0,1, 1,0);
    add(0,0,0, 0,1, 0,1, 1,0);
    add(0,0,0, 0,1, 0,0, 1,0);
    add(0,0,0, 0,1, 0,0, 0,1);
    add(0,0,0, 0,1, 0,0, 0,1);
    // C: restart from DONE with out-of-range preset, then preset 00.
    add(1,0,0, 12,15, 9,9, 0,1);
    add(0,0,0, 12,15, 9,9, 1,0);
    add(1,0,0, 12,15, 9,9, 1,0);
    add(0,0,1, 12,15, 9,9, 1,0);
    add(0,0,0, 0,0, 0,0, 0,0);
    add(1,0,0, 0,0, 0,0, 0,0);
    add(0,0,0, 0,0, 0,0, 0,1);
    add(0,0,1, 0,0, 0,0, 0,1);
    add(0,0,0, 0,0, 0,0, 0,0);

    // Reset state
    #12;
    chk("rst_digits", {bcd_tens, bcd_ones}, 8'h00);
    chk("rst_flags", {6'd0, running, done}, 8'h00);
    chk("rst_scan", {3'd0, digit_sel, digit_bcd}, 8'h00);
    @(posedge clock); #1;
    reset_n = 1'b1;
    preset_tens = 4'd1; preset_ones = 4'd2;
    step(2);
    chk_digits("idle_track", 4'd1, 4'd2);

    foreach (vecs[i]) begin
      start = vecs[i].st; pause = vecs[i].pa; clear = vecs[i].cl;
      preset_tens = vecs[i].pt; preset_ones = vecs[i].po;
      step(1);
      chk($sformatf("vec%0d_digits", i), {bcd_tens, bcd_ones}, {vecs[i].et, vecs[i].eo});
      chk($sformatf("vec%0d_flags", i), {6'd0, running, done}, {6'd0, vecs[i].er, vecs[i].ed});
    end
    start = 1'b0; pause = 1'b0; clear = 1'b0;

    // Pause with held prescaler, resume, then pause on a tick edge.
    preset_tens = 4'd0; preset_ones = 4'd5;
    step(1);
    pulse(0);
    step(3);
    chk_digits("p_before_tick", 4'd0, 4'd5);
    step(1);
    chk_digits("p_first_tick", 4'd0, 4'd4);
    step(2);
    pulse(1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_digits("p_frozen", 4'd0, 4'd4);
    end
    chk("p_not_running", {7'd0, running}, 8'd0);
    pulse(0);
    chk_digits("p_resume0", 4'd0, 4'd4);
    step(1);
    chk_digits("p_resume1", 4'd0, 4'd4);
    step(1);
    chk_digits("p_resume2", 4'd0, 4'd3);
    step(3);
    chk_digits("p_pre_tick", 4'd0, 4'd3);
    pulse(1);
    chk_digits("p_tick_pause", 4'd0, 4'd2);
    step(3);
    chk_digits("p_tick_frozen", 4'd0, 4'd2);
    chk("p_tick_state", {6'd0, running, done}, 8'd0);
    pulse(2);
    step(1);

    // Terminal count holds at 00.
    preset_tens = 4'd0; preset_ones = 4'd1;
    step(1);
    pulse(0);
    step(4);
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk_digits("d_hold", 4'd0, 4'd0);
      chk("d_flag", {6'd0, running, done}, 8'd1);
    end
    pulse(2);
    step(1);

    // Asynchronous reset in the middle of a count.
    preset_tens = 4'd0; preset_ones = 4'd5;
    step(1);
    pulse(0);
    step(2);
    chk("r_running", {7'd0, running}, 8'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("r_async_digits", {bcd_tens, bcd_ones}, 8'h00);
    chk("r_async_flags", {6'd0, running, done}, 8'h00);
    chk("r_async_scan", {3'd0, digit_sel, digit_bcd}, 8'h00);
    preset_tens = 4'd4; preset_ones = 4'd7;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Scan after release: sel toggles every 3 edges, digit_bcd lags one edge.
    exp_sel = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      prev_sel = exp_sel;
      exp_sel  = ((k / 3) % 2) == 1;
      exp_dbcd = (k == 1) ? 4'd0 : (prev_sel ? 4'd4 : 4'd7);
      step(1);
      chk($sformatf("s_sel%0d", k), {7'd0, digit_sel}, {7'd0, exp_sel});
      chk($sformatf("s_bcd%0d", k), {4'd0, digit_bcd}, {4'd0, exp_dbcd});
    end
    chk_digits("s_idle_digits", 4'd4, 4'd7);
    chk("s_idle_flags", {6'd0, running, done}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
